// File: rtl/stream_demux_1ton_pkg.sv
// Shared types, defaults and helpers for the 1-to-N valid/ready stream demux.
package stream_demux_pkg;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_SEL_W = 2;
  localparam int unsigned DEF_CNT_W = 8;

  // Beat layout at default widths; the top re-declares it with its own parameters.
  typedef struct packed {
    logic [DEF_SEL_W-1:0] sel;
    logic [DEF_W-1:0]     data;
  } beat_t;

  // Occupancy of the 2-entry elastic buffer.
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_level_e;

  // True when a select addresses an existing output.
  function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/stream_demux_1ton_fifo2.sv
// Two-entry register FIFO; full/empty come straight from registered state.
module fifo2
  import stream_demux_pkg::*;
#(
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  fifo_level_e   level_q, level_d;
  logic          do_push, do_pop;

  // Next-state: guarded push/pop, pointers wrap modulo 2, level tracks occupancy.
  always_comb begin
    do_push  = push & (level_q != FIFO_FULL);
    do_pop   = pop  & (level_q != FIFO_EMPTY);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = (level_q == FIFO_EMPTY) ? FIFO_ONE : FIFO_FULL;
      2'b01:   level_d = (level_q == FIFO_FULL)  ? FIFO_ONE : FIFO_EMPTY;
      default: level_d = level_q;
    endcase
  end

  // State registers; reset empties the buffer and clears storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= FIFO_EMPTY;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign full  = (level_q == FIFO_FULL);
  assign empty = (level_q == FIFO_EMPTY);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/stream_demux_1ton.sv
// Routes one valid/ready stream to one of N outputs by a per-beat select,
// through a 2-entry elastic buffer; out-of-range beats are dropped and counted.
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned SEL_W = DEF_SEL_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [W-1:0]     up_data,
  input  logic [SEL_W-1:0] up_sel,
  output logic [N-1:0]     down_valid,
  input  logic [N-1:0]     down_ready,
  output logic [W-1:0]     down_data,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             drop_pulse
);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     data;
  } beat_w_t;

  beat_w_t          push_beat, head_beat;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop;
  logic             head_in_range;
  logic [W-1:0]     data_hold_q, data_hold_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             drop_pulse_q, drop_pulse_d;

  // Ready depends only on registered occupancy, so there is no up_valid->up_ready path.
  assign up_ready  = ~fifo_full;
  assign push      = up_valid & up_ready;
  assign push_beat = '{sel: up_sel, data: up_data};

  fifo2 #(
    .DW($bits(beat_w_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (push_beat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_beat)
  );

  // Head routing: one-hot valid for in-range heads, immediate pop+drop for out-of-range heads.
  always_comb begin
    head_in_range = sel_in_range(32'(head_beat.sel), N);
    down_valid    = '0;
    pop           = 1'b0;
    drop          = 1'b0;
    if (!fifo_empty) begin
      if (head_in_range) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (32'(head_beat.sel) == k) begin
            down_valid[k] = 1'b1;
            pop           = down_ready[k];
          end
        end
      end else begin
        pop  = 1'b1;
        drop = 1'b1;
      end
    end
  end

  // Payload follows the routed head; otherwise the last routed value is held.
  always_comb begin
    down_data   = (!fifo_empty && head_in_range) ? head_beat.data : data_hold_q;
    data_hold_d = down_data;
  end

  // Drop bookkeeping: saturating counter and a pulse one cycle after each drop.
  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = drop;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // Registers for held payload and drop status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_hold_q  <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      data_hold_q  <= data_hold_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign drop_cnt   = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;

endmodule
